// File: rtl/mc_bus_pkg.sv
// Shared encodings for the bus-attached multicycle datapath: access sizes, mux
// selects, ALU/immediate codes, bus FSM states and the byte-lane count helper.
package mc_bus_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    typedef enum logic {
        BUS_IDLE,
        BUS_WAIT
    } bus_state_e;

    function automatic int unsigned lane_count(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mc_lsu_align.sv
// Load/store lane handling: store replication and byte enables, load extraction
// with sign/zero extension, and the alignment check for a requested access.
module mc_lsu_align
    import mc_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2:0]                      addr_lo_i,
    input  logic [1:0]                      size_i,
    input  logic                            unsigned_i,
    input  logic [DATA_WIDTH-1:0]           store_i,
    input  logic [DATA_WIDTH-1:0]           rdata_i,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    output logic [lane_count(DATA_WIDTH)-1:0] be_o,
    output logic [DATA_WIDTH-1:0]           load_o,
    output logic                            misaligned_o
);
    localparam int unsigned N  = lane_count(DATA_WIDTH);
    localparam int unsigned OW = $clog2(N);
    localparam logic [N-1:0] BE_B = (N)'(1);
    localparam logic [N-1:0] BE_H = (N)'(3);
    localparam logic [N-1:0] BE_W = (N)'(15);

    logic [OW-1:0]         off;
    logic [DATA_WIDTH-1:0] sh;

    assign off = addr_lo_i[OW-1:0];
    assign sh  = rdata_i >> {off, 3'b000};

    always_comb begin
        wdata_o      = store_i;
        be_o         = '1;
        load_o       = sh;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_B: begin
                wdata_o = {N{store_i[7:0]}};
                be_o    = BE_B << off;
                load_o  = unsigned_i ? DATA_WIDTH'(sh[7:0]) : DATA_WIDTH'($signed(sh[7:0]));
            end
            SZ_H: begin
                wdata_o      = {(N/2){store_i[15:0]}};
                be_o         = BE_H << off;
                load_o       = unsigned_i ? DATA_WIDTH'(sh[15:0]) : DATA_WIDTH'($signed(sh[15:0]));
                misaligned_o = addr_lo_i[0];
            end
            SZ_W: begin
                wdata_o      = {(N/4){store_i[31:0]}};
                be_o         = BE_W << off;
                load_o       = unsigned_i ? DATA_WIDTH'(sh[31:0]) : DATA_WIDTH'($signed(sh[31:0]));
                misaligned_o = addr_lo_i[1:0] != 2'b00;
            end
            default: begin
                misaligned_o = (DATA_WIDTH == 32) || (addr_lo_i != 3'b000);
            end
        endcase
    end

endmodule

// File: rtl/mc_datapath_bus.sv
// Multicycle RISC-V datapath with a request/acknowledge memory port; the bus
// FSM latches the access at request and completes loads/fetches on bus_ack.
module mc_datapath_bus
    import mc_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            PCWrite,
    input  logic                            RegWrite,
    input  logic                            IRWrite,
    input  logic [1:0]                      ResultSrc,
    input  logic [1:0]                      ALUSrcA,
    input  logic [1:0]                      ALUSrcB,
    input  logic [3:0]                      ALUControl,
    input  logic [2:0]                      ImmSrc,
    input  logic                            ADRSrc,
    input  logic                            MemReq,
    input  logic                            MemWrite,
    input  logic [1:0]                      MemSize,
    input  logic                            MemUnsigned,
    output logic                            bus_req,
    output logic                            bus_we,
    output logic [DATA_WIDTH-1:0]           bus_addr,
    output logic [DATA_WIDTH-1:0]           bus_wdata,
    output logic [lane_count(DATA_WIDTH)-1:0] bus_be,
    input  logic [DATA_WIDTH-1:0]           bus_rdata,
    input  logic                            bus_ack,
    output logic                            MemBusy,
    output logic                            MemDone,
    output logic                            Misaligned,
    output logic                            Zero,
    output logic [6:0]                      Op,
    output logic [2:0]                      Funct3,
    output logic [6:0]                      Funct7
);
    localparam int unsigned NB = lane_count(DATA_WIDTH);
    localparam int unsigned RW = $clog2(NUM_REGS);
    localparam int unsigned SW = $clog2(DATA_WIDTH);

    bus_state_e state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, oldpc_q, a_q, b_q, aluout_q, data_q;
    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
    logic [31:0]           ir_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q;
    logic [NB-1:0]         be_q;
    logic [1:0]            size_q;
    logic                  we_q, uns_q, fetch_q, done_q, mis_q;

    logic [RW-1:0]         rs1, rs2, rd;
    logic [DATA_WIDTH-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result, adr;
    logic [31:0]           imm32, ir_word;
    logic [SW-1:0]         shamt;
    logic                  req_ok, req_bad, ack_ok, idle;
    logic [2:0]            lsu_addr;
    logic [1:0]            lsu_size;
    logic                  lsu_uns, lsu_mis;
    logic [DATA_WIDTH-1:0] lsu_wdata, lsu_load;
    logic [NB-1:0]         lsu_be;

    assign rs1 = ir_q[15 +: RW];
    assign rs2 = ir_q[20 +: RW];
    assign rd  = ir_q[7 +: RW];
    assign rd1 = (rs1 == '0) ? '0 : rf_q[rs1];
    assign rd2 = (rs2 == '0) ? '0 : rf_q[rs2];

    always_comb begin
        case (ImmSrc)
            IMM_S:   imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            IMM_B:   imm32 = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            IMM_J:   imm32 = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            IMM_U:   imm32 = {ir_q[31:12], 12'h000};
            default: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
        endcase
    end
    assign imm_ext = DATA_WIDTH'($signed(imm32));

    always_comb begin
        case (ALUSrcA)
            SRCA_PC:    src_a = pc_q;
            SRCA_OLDPC: src_a = oldpc_q;
            default:    src_a = a_q;
        endcase
        case (ALUSrcB)
            SRCB_B:    src_b = b_q;
            SRCB_IMM:  src_b = imm_ext;
            default:   src_b = DATA_WIDTH'(4);
        endcase
    end

    assign shamt = src_b[SW-1:0];
    always_comb begin
        case (ALUControl)
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = DATA_WIDTH'($signed(src_a) < $signed(src_b));
            ALU_SLTU: alu_result = DATA_WIDTH'(src_a < src_b);
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
            default:  alu_result = src_a + src_b;
        endcase
        case (ResultSrc)
            RES_DATA:      result = data_q;
            RES_ALURESULT: result = alu_result;
            default:       result = aluout_q;
        endcase
    end

    assign Zero = (alu_result == '0);
    assign adr  = ADRSrc ? result : pc_q;

    // One aligner serves both the request (live address) and the completion (latched address).
    assign idle     = (state_q == BUS_IDLE);
    assign lsu_addr = idle ? adr[2:0] : addr_q[2:0];
    assign lsu_size = idle ? MemSize : size_q;
    assign lsu_uns  = idle ? MemUnsigned : uns_q;

    mc_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .addr_lo_i    (lsu_addr),
        .size_i       (lsu_size),
        .unsigned_i   (lsu_uns),
        .store_i      (b_q),
        .rdata_i      (bus_rdata),
        .wdata_o      (lsu_wdata),
        .be_o         (lsu_be),
        .load_o       (lsu_load),
        .misaligned_o (lsu_mis)
    );

    always_comb begin
        state_d = state_q;
        req_ok  = 1'b0;
        req_bad = 1'b0;
        ack_ok  = 1'b0;
        case (state_q)
            BUS_IDLE: if (MemReq) begin
                if (lsu_mis) begin
                    req_bad = 1'b1;
                end else begin
                    req_ok  = 1'b1;
                    state_d = BUS_WAIT;
                end
            end
            BUS_WAIT: if (bus_ack) begin
                ack_ok  = 1'b1;
                state_d = BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= BUS_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            fetch_q <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            done_q <= ack_ok;
            mis_q  <= req_bad;
            if (req_ok) begin
                addr_q  <= adr;
                wdata_q <= lsu_wdata;
                be_q    <= lsu_be;
                size_q  <= MemSize;
                we_q    <= MemWrite;
                uns_q   <= MemUnsigned;
                fetch_q <= IRWrite;
            end
        end
    end

    assign ir_word = (DATA_WIDTH == 64 && addr_q[2]) ? 32'(bus_rdata >> 32) : 32'(bus_rdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= DATA_WIDTH'(RESET_PC);
            oldpc_q  <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            data_q   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            a_q      <= rd1;
            b_q      <= rd2;
            aluout_q <= alu_result;
            if (PCWrite) pc_q <= result;
            if (RegWrite && rd != '0) rf_q[rd] <= result;
            if (ack_ok && !we_q) begin
                data_q <= lsu_load;
                if (fetch_q) begin
                    ir_q    <= ir_word;
                    oldpc_q <= pc_q;
                end
            end
        end
    end

    assign bus_req    = (state_q == BUS_WAIT);
    assign MemBusy    = (state_q == BUS_WAIT);
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign bus_be     = be_q;
    assign MemDone    = done_q;
    assign Misaligned = mis_q;
    assign Op         = ir_q[6:0];
    assign Funct3     = ir_q[14:12];
    assign Funct7     = ir_q[31:25];

endmodule
